dmrl3_sched: RTL and testbench

DMRL3_SCHED -- requirements
Module: dmrl3_sched

---
 rtl/dmrl3_sched_pkg.sv | 31 +++
 rtl/dmrl3_evt_match.sv | 33 +++
 rtl/dmrl3_sched.sv | 154 +++++++++++++++
 tb/tb_dmrl3_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dmrl3_sched_pkg.sv
// Shared types and constants for the dmrl3 frame scheduler: entry layout,
// channel encoding, FSM states and default frame period.
package dmrl3_sched_pkg;

  localparam int TIME_W     = 15;
  localparam int CH_W       = 2;
  localparam int N_CH       = 3;
  localparam int ADDR_W     = 4;
  localparam int ENTRY_W    = 19;
  localparam int PERIOD_DEF = 15000;

  localparam logic [CH_W-1:0] CH_MOD   = 2'd0;
  localparam logic [CH_W-1:0] CH_GEN   = 2'd1;
  localparam logic [CH_W-1:0] CH_SINHR = 2'd2;
  localparam logic [CH_W-1:0] CH_OFF   = 2'd3;

  // Field order matches the cfg_data bit layout, MSB first.
  typedef struct packed {
    logic              off;
    logic              lvl;
    logic [CH_W-1:0]   ch;
    logic [TIME_W-1:0] tm;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/dmrl3_evt_match.sv
// Combinational event matcher: compares every enabled entry against the
// frame timer and resolves per-channel hits, highest index winning.
module dmrl3_evt_match
  import dmrl3_sched_pkg::*;
#(
  parameter int N_EVT = 16
) (
  input  entry_t [N_EVT-1:0] entries,
  input  logic [TIME_W-1:0]  timer,
  input  logic [TIME_W-1:0]  period,
  input  logic [TIME_W-1:0]  offset,
  output logic [N_CH-1:0]    hit,
  output logic [N_CH-1:0]    lvl
);

  logic [TIME_W:0] eff;

  // Ascending scan lets a later (higher) index overwrite an earlier hit.
  always_comb begin
    hit = '0;
    lvl = '0;
    eff = '0;
    for (int i = 0; i < N_EVT; i++) begin
      eff = {1'b0, entries[i].tm} + (entries[i].off ? {1'b0, offset} : '0);
      if ((entries[i].ch != CH_OFF) && (eff == {1'b0, timer}) &&
          (eff < {1'b0, period})) begin
        hit[entries[i].ch] = 1'b1;
        lvl[entries[i].ch] = entries[i].lvl;
      end
    end
  end

endmodule

// File: rtl/dmrl3_sched.sv
// Frame scheduler driving upr_mod/upr_gen/sinhr from a timed event table.
// Define DMRL3_OFFSET_EN to add the off_we/off_data offset register.
module dmrl3_sched #(
  parameter int N_EVT      = 16,
  parameter int PERIOD_DEF = dmrl3_sched_pkg::PERIOD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [18:0] cfg_data,
  input  logic        per_we,
  input  logic [14:0] per_data,
`ifdef DMRL3_OFFSET_EN
  input  logic        off_we,
  input  logic [14:0] off_data,
`endif
  input  logic        start,
  input  logic        stop,
  output logic        upr_mod,
  output logic        upr_gen,
  output logic        sinhr,
  output logic        busy,
  output logic        frame_strobe,
  output logic        cfg_err
);

  import dmrl3_sched_pkg::*;

  localparam logic [TIME_W-1:0] PER_RST   = TIME_W'(PERIOD_DEF);
  localparam entry_t            ENTRY_RST = '{off: 1'b0, lvl: 1'b0, ch: CH_OFF, tm: '0};

  state_t              state_q, state_d;
  logic [TIME_W-1:0]   timer_q, timer_d;
  logic [TIME_W-1:0]   period_q, period_d;
  logic [TIME_W-1:0]   per_sh_q, per_sh_d;
  entry_t [N_EVT-1:0]  entry_q, entry_d;
  logic [N_CH-1:0]     out_q, out_d;
  logic                frame_q, frame_d;
  logic                err_q, err_d;
  logic [N_CH-1:0]     hit, hit_lvl;
  logic [TIME_W-1:0]   offset_cur;
  logic                active, wrap;

  assign active = (state_q != ST_IDLE);
  assign wrap   = active && (timer_q == period_q - 15'd1);

`ifdef DMRL3_OFFSET_EN
  logic [TIME_W-1:0] offset_q, offset_d, off_sh_q, off_sh_d;

  always_comb begin
    off_sh_d = off_sh_q;
    offset_d = offset_q;
    if (off_we) off_sh_d = off_data;
    if (!active || wrap) offset_d = off_sh_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q <= '0;
      off_sh_q <= '0;
    end else begin
      offset_q <= offset_d;
      off_sh_q <= off_sh_d;
    end
  end

  assign offset_cur = offset_q;
`else
  assign offset_cur = '0;
`endif

  dmrl3_evt_match #(
    .N_EVT (N_EVT)
  ) u_match (
    .entries (entry_q),
    .timer   (timer_q),
    .period  (period_q),
    .offset  (offset_cur),
    .hit     (hit),
    .lvl     (hit_lvl)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start && !stop) state_d = ST_RUN;
      ST_RUN:   if (stop) state_d = ST_DRAIN;
      ST_DRAIN: if (wrap) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    timer_d = '0;
    if (active && !wrap) timer_d = timer_q + 15'd1;

    // Shadow takes the new period; the live period follows it while idle
    // or at the frame wrap so a running frame never changes length.
    err_d    = 1'b0;
    per_sh_d = per_sh_q;
    period_d = period_q;
    if (per_we) begin
      if (per_data < 15'd2) err_d = 1'b1;
      else                  per_sh_d = per_data;
    end
    if (!active || wrap) period_d = per_sh_d;

    entry_d = entry_q;
    if (cfg_we) begin
      for (int i = 0; i < N_EVT; i++) begin
        if (cfg_addr == ADDR_W'(i)) entry_d[i] = entry_t'(cfg_data);
      end
    end

    out_d = out_q;
    if (active) begin
      for (int c = 0; c < N_CH; c++) begin
        if (hit[c]) out_d[c] = hit_lvl[c];
      end
    end
    if (state_d == ST_IDLE) out_d = '0;

    frame_d = active && (timer_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      period_q <= PER_RST;
      per_sh_q <= PER_RST;
      entry_q  <= {N_EVT{ENTRY_RST}};
      out_q    <= '0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      per_sh_q <= per_sh_d;
      entry_q  <= entry_d;
      out_q    <= out_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  assign upr_mod      = out_q[CH_MOD];
  assign upr_gen      = out_q[CH_GEN];
  assign sinhr        = out_q[CH_SINHR];
  assign busy         = active;
  assign frame_strobe = frame_q;
  assign cfg_err      = err_q;

endmodule

// File: tb/tb_dmrl3_sched.sv
// Directed bench for dmrl3_sched; t=k comments give the DUT timer value
// held in the interval where the following checks sample.
module tb_dmrl3_sched;

  logic        clk = 1'b0;
  logic        rst, cfg_we, per_we, start, stop;
  logic [3:0]  cfg_addr;
  logic [18:0] cfg_data;
  logic [14:0] per_data;
  logic        off_we;
  logic [14:0] off_data;
  logic        upr_mod, upr_gen, sinhr, busy, frame_strobe, cfg_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmrl3_sched dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .per_we       (per_we),
    .per_data     (per_data),
`ifdef DMRL3_OFFSET_EN
    .off_we       (off_we),
    .off_data     (off_data),
`endif
    .start        (start),
    .stop         (stop),
    .upr_mod      (upr_mod),
    .upr_gen      (upr_gen),
    .sinhr        (sinhr),
    .busy         (busy),
    .frame_strobe (frame_strobe),
    .cfg_err      (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_evt(input int addr, input int tm, input int ch, input bit lvl, input bit off);
    cfg_addr = 4'(addr);
    cfg_data = {off, lvl, 2'(ch), 15'(tm)};
    cfg_we   = 1'b1;
    adv(1);
    cfg_we   = 1'b0;
  endtask

  task automatic wr_per(input int p);
    per_data = 15'(p);
    per_we   = 1'b1;
    adv(1);
    per_we   = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    adv(1);
    rst = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    adv(1);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; per_we = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_addr = '0; cfg_data = '0; per_data = '0; off_we = 1'b0; off_data = '0;
    adv(2);
    rst = 1'b0;
    chk("rst_upr_mod", upr_mod, 0);
    chk("rst_upr_gen", upr_gen, 0);
    chk("rst_sinhr", sinhr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_strobe", frame_strobe, 0);
    chk("rst_cfg_err", cfg_err, 0);

    wr_evt(0, 0, 0, 1, 0);
    wr_evt(1, 13, 0, 0, 0);
    wr_evt(2, 5, 1, 1, 0);
    wr_evt(7, 5, 1, 0, 0);
    wr_evt(3, 20, 2, 1, 0);
    wr_evt(5, 100, 1, 1, 0);
    wr_per(100);
    chk("per100_no_err", cfg_err, 0);
    wr_per(1);
    chk("per1_err_pulse", cfg_err, 1);
    adv(1);
    chk("per1_err_clear", cfg_err, 0);

    start = 1'b1; stop = 1'b1;
    adv(1);
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", busy, 0);
    adv(1);
    chk("start_stop_idle2", busy, 0);

    do_start;                                    // t=0
    chk("run_busy", busy, 1);
    chk("t0_upr_mod", upr_mod, 0);
    adv(1);                                      // t=1
    chk("t1_upr_mod_rise", upr_mod, 1);
    chk("t1_frame_strobe", frame_strobe, 1);
    adv(1);                                      // t=2
    chk("t2_frame_strobe", frame_strobe, 0);
    adv(4);                                      // t=6
    chk("t6_upr_gen_prio", upr_gen, 0);
    adv(7);                                      // t=13
    chk("t13_upr_mod", upr_mod, 1);
    adv(1);                                      // t=14
    chk("t14_upr_mod_fall", upr_mod, 0);
    adv(7);                                      // t=21
    chk("t21_sinhr", sinhr, 1);
    adv(19);                                     // t=40
    wr_per(200);                                 // t=41
    chk("per200_no_err", cfg_err, 0);
    adv(58);                                     // t=99
    chk("t99_frame_strobe", frame_strobe, 0);
    adv(1);                                      // t=0, frame of 200
    adv(1);                                      // t=1
    chk("f2_t1_frame_strobe", frame_strobe, 1);
    chk("f2_t1_upr_mod", upr_mod, 1);
    adv(98);                                     // t=99
    chk("f2_t99_upr_gen", upr_gen, 0);
    adv(2);                                      // t=101
    chk("f2_t101_no_wrap_strobe", frame_strobe, 0);
    chk("f2_t101_upr_mod", upr_mod, 0);
    chk("f2_t101_upr_gen_t100", upr_gen, 1);
    adv(98);                                     // t=199
    adv(2);                                      // t=1 of frame 3
    chk("f3_t1_frame_strobe", frame_strobe, 1);
    chk("f3_t1_upr_mod", upr_mod, 1);
    wr_per(100);                                 // t=2
    adv(197);                                    // t=199
    chk("f3_t199_busy", busy, 1);
    adv(1);                                      // t=0, frame of 100
    adv(30);                                     // t=30
    stop = 1'b1;
    adv(1);                                      // t=31
    stop = 1'b0;
    chk("drain_busy", busy, 1);
    adv(68);                                     // t=99
    chk("drain_t99_busy", busy, 1);
    chk("drain_t99_sinhr", sinhr, 1);
    adv(1);
    chk("idle_busy", busy, 0);
    chk("idle_sinhr", sinhr, 0);
    chk("idle_upr_gen", upr_gen, 0);
    adv(2);
    chk("idle_stays", busy, 0);

    do_start;                                    // t=0
    adv(50);                                     // t=50
    chk("pre_rst_sinhr", sinhr, 1);
    do_reset;
    chk("mid_rst_sinhr", sinhr, 0);
    chk("mid_rst_upr_gen", upr_gen, 0);
    chk("mid_rst_upr_mod", upr_mod, 0);
    chk("mid_rst_busy", busy, 0);
    do_start;                                    // t=0
    adv(1);                                      // t=1
    chk("post_rst_strobe", frame_strobe, 1);
    chk("post_rst_upr_mod", upr_mod, 0);
    adv(5);                                      // t=6
    chk("post_rst_upr_gen", upr_gen, 0);
    adv(15);                                     // t=21
    chk("post_rst_sinhr", sinhr, 0);
    do_reset;

`ifdef DMRL3_OFFSET_EN
    wr_per(500);
    off_data = 15'd50; off_we = 1'b1;
    adv(1);
    off_we = 1'b0;
    wr_evt(0, 356, 0, 1, 1);
    do_start;                                    // t=0
    adv(406);                                    // t=406
    chk("off1_t406", upr_mod, 0);
    adv(1);                                      // t=407
    chk("off1_t407_rise", upr_mod, 1);
    do_reset;
    wr_per(500);
    off_data = 15'd50; off_we = 1'b1;
    adv(1);
    off_we = 1'b0;
    wr_evt(0, 356, 0, 1, 0);
    do_start;                                    // t=0
    adv(356);                                    // t=356
    chk("off0_t356", upr_mod, 0);
    adv(1);                                      // t=357
    chk("off0_t357_rise", upr_mod, 1);
    do_reset;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
